// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus the sub-word alignment helper used by the master.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Size code 3 would be a 64-bit beat on a 32-bit bus, so it is rejected too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb_lite_master_lane.sv
// Byte-lane steering for sub-word transfers: write-data replication and read-data
// extraction with zero extension. Purely combinational.
module ahb_lite_master_lane (
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rd_lanes,
    output logic [31:0] rd_data
);

    always_comb begin
        wr_lanes = wr_data;
        case (wr_size)
            2'd0:    wr_lanes = {4{wr_data[7:0]}};
            2'd1:    wr_lanes = {2{wr_data[15:0]}};
            default: wr_lanes = wr_data;
        endcase
    end

    always_comb begin
        rd_data = rd_lanes;
        case (rd_size)
            2'd0:    rd_data = {24'b0, rd_lanes[{rd_addr_lo, 3'b000} +: 8]};
            2'd1:    rd_data = {16'b0, rd_lanes[{rd_addr_lo[1], 4'b0000} +: 16]};
            default: rd_data = rd_lanes;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite SINGLE-transfer master with overlapped address/data phases and ERROR replay.
// Optional sub-word support is enabled by defining AHB_LITE_MASTER_SUBWORD_EN.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DATA_WIDTH-1:0] hrdata
);

    logic                  ap_vld, ap_write, ap_mis;
    logic [ADDR_WIDTH-1:0] ap_addr;
    logic [2:0]            ap_size;
    logic [DATA_WIDTH-1:0] ap_wdata;
    logic                  dp_vld, dp_mis, dp_write;
    logic [DATA_WIDTH-1:0] dp_wdata;
    logic                  replay;

    logic                  accept, ap_take, dp_done;
    logic [ADDR_WIDTH-1:0] req_haddr;
    logic [2:0]            req_hsize;
    logic                  req_mis;
    logic [DATA_WIDTH-1:0] req_wlanes, rd_extract;

`ifdef AHB_LITE_MASTER_SUBWORD_EN
    logic [1:0] dp_size, dp_addr_lo;

    ahb_lite_master_lane u_lane (
        .wr_size    (req_size),
        .wr_data    (req_wdata),
        .wr_lanes   (req_wlanes),
        .rd_size    (dp_size),
        .rd_addr_lo (dp_addr_lo),
        .rd_lanes   (hrdata),
        .rd_data    (rd_extract)
    );

    assign req_haddr = req_addr;
    assign req_hsize = {1'b0, req_size};
    assign req_mis   = is_misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_size    <= 2'd2;
            dp_addr_lo <= 2'b00;
        end else if (hready) begin
            dp_size    <= ap_size[1:0];
            dp_addr_lo <= ap_addr[1:0];
        end
    end
`else
    logic size_unused;

    assign size_unused = ^req_size;
    assign req_haddr   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign req_hsize   = HSIZE_WORD;
    assign req_mis     = 1'b0;
    assign req_wlanes  = req_wdata;
    assign rd_extract  = hrdata;
`endif

    // Bus outputs come only from the pipeline registers; req_* never reaches them directly.
    assign htrans    = (ap_vld && !replay && !ap_mis) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = ap_addr;
    assign hwrite    = ap_write;
    assign hsize     = ap_size;
    assign hburst    = HBURST_SINGLE;
    assign hwdata    = dp_wdata;

    assign req_ready = !ap_vld || (hready && !hresp);
    assign accept    = req_valid && req_ready;
    // A misaligned entry never reaches the bus; it walks through the data slot so
    // its error response stays in request order.
    assign ap_take   = hready && ap_vld &&
                       ((htrans == HTRANS_NONSEQ) || (ap_mis && !(dp_vld && hresp)));
    assign dp_done   = hready && (dp_vld || dp_mis);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap_vld    <= 1'b0;
            ap_addr   <= '0;
            ap_write  <= 1'b0;
            ap_size   <= HSIZE_WORD;
            ap_wdata  <= '0;
            ap_mis    <= 1'b0;
            dp_vld    <= 1'b0;
            dp_mis    <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            replay    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                ap_vld   <= 1'b1;
                ap_addr  <= req_haddr;
                ap_write <= req_write;
                ap_size  <= req_hsize;
                ap_wdata <= req_wlanes;
                ap_mis   <= req_mis;
            end else if (ap_take) begin
                ap_vld <= 1'b0;
            end

            if (hready) begin
                dp_vld   <= ap_vld && (htrans == HTRANS_NONSEQ);
                dp_mis   <= ap_take && ap_mis;
                dp_write <= ap_write;
                dp_wdata <= ap_wdata;
            end

            // First ERROR cycle parks the address phase; it reissues once the error retires.
            if (dp_vld && hresp && !hready) begin
                replay <= 1'b1;
            end else if (hready) begin
                replay <= 1'b0;
            end

            rsp_valid <= dp_done;
            if (dp_done) begin
                rsp_err   <= dp_mis || (dp_vld && hresp == HRESP_ERROR);
                rsp_rdata <= (dp_mis || dp_write || hresp) ? '0 : rd_extract;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a behavioural AHB slave (waits, two-cycle ERROR).
// Sub-word steps run only when AHB_LITE_MASTER_SUBWORD_EN is defined.
module tb_ahb_lite_master;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize, hburst;

    ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:255];
    logic        sl_vld, sl_write, sl_err, sl_ph;
    logic [31:0] sl_addr;
    logic [2:0]  sl_size;
    int          sl_cnt;
    logic [31:0] wait_addr = 32'hFFFF_FFFC;
    int          wait_n = 0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        if (sl_vld) begin
            if (sl_err) begin
                hresp  = 1'b1;
                hready = sl_ph;
            end else if (sl_cnt > 0) begin
                hready = 1'b0;
            end
        end
        hrdata = (sl_vld && sl_err) ? 32'hBAD0_BAD0 : mem[sl_addr[9:2]];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_vld <= 1'b0; sl_write <= 1'b0; sl_err <= 1'b0; sl_ph <= 1'b0;
            sl_addr <= '0; sl_size <= 3'd2; sl_cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (hready) begin
            if (sl_vld && sl_write && !sl_err) begin
                case (sl_size)
                    3'd0:    mem[sl_addr[9:2]][{sl_addr[1:0], 3'b000} +: 8] <= hwdata[{sl_addr[1:0], 3'b000} +: 8];
                    3'd1:    mem[sl_addr[9:2]][{sl_addr[1], 4'b0000} +: 16] <= hwdata[{sl_addr[1], 4'b0000} +: 16];
                    default: mem[sl_addr[9:2]] <= hwdata;
                endcase
            end
            sl_vld   <= (htrans == T_NONSEQ);
            sl_addr  <= haddr;
            sl_write <= hwrite;
            sl_size  <= hsize;
            sl_err   <= (haddr == err_addr);
            sl_ph    <= 1'b0;
            sl_cnt   <= (haddr == wait_addr) ? wait_n : 0;
        end else begin
            if (sl_err) sl_ph <= 1'b1;
            else if (sl_cnt > 0) sl_cnt <= sl_cnt - 1;
        end
    end

    // ---------------- monitor ----------------
    logic [1:0]  htr_log [0:4095];
    logic [31:0] adr_log [0:4095];
    logic [2:0]  hsz_log [0:4095];
    logic [31:0] hwd_log [0:4095];
    logic [31:0] rsp_data_a [0:255];
    logic        rsp_err_a  [0:255];
    int          rsp_cyc_a  [0:255];
    int          rsp_n = 0;

    always @(negedge clk) begin
        if (!rst) begin
            htr_log[cyc[11:0]] <= htrans;
            adr_log[cyc[11:0]] <= haddr;
            hsz_log[cyc[11:0]] <= hsize;
            hwd_log[cyc[11:0]] <= hwdata;
            if (rsp_valid) begin
                rsp_data_a[rsp_n[7:0]] <= rsp_rdata;
                rsp_err_a[rsp_n[7:0]]  <= rsp_err;
                rsp_cyc_a[rsp_n[7:0]]  <= cyc;
                rsp_n <= rsp_n + 1;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] li(input int c);
        return c[11:0];
    endfunction

    function automatic logic [7:0] ri(input int c);
        return c[7:0];
    endfunction

    function automatic logic [31:0] wdat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0111;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic [31:0] d, output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = s; req_wdata = d;
        #1;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("req_accept", 32'(req_ready), 32'd1);
        acc = cyc + 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int base, input int n);
        int budget;
        budget = 0;
        while ((rsp_n - base) < n && budget < 60) begin
            @(negedge clk);
            #2;
            budget++;
        end
        chk("rsp_count", 32'(rsp_n - base), 32'(n));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_htrans"},    32'(htrans), 32'(T_IDLE));
        chk({tag, "_haddr"},     haddr, 32'd0);
        chk({tag, "_hwrite"},    32'(hwrite), 32'd0);
        chk({tag, "_hsize"},     32'(hsize), 32'd2);
        chk({tag, "_hburst"},    32'(hburst), 32'd0);
        chk({tag, "_hwdata"},    hwdata, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0, a1, b0, x, y, base, cnt;
        int acc_a[16];
        logic [31:0] e;

        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = 2'd2; req_wdata = '0;
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Write then read one word; response lands in cycle T2 (two edges after accept).
        base = rsp_n;
        send(32'h8000_0010, 1'b1, 2'd2, 32'hDEAD_BEEF, a0);
        send(32'h8000_0010, 1'b0, 2'd2, 32'h0, a1);
        wait_rsp(base, 2);
        chk("t1_htrans", 32'(htr_log[li(a0)]), 32'(T_NONSEQ));
        chk("t1_hwdata", hwd_log[li(a0 + 1)], 32'hDEAD_BEEF);
        chk("t1_wr_err", 32'(rsp_err_a[ri(base)]), 32'd0);
        chk("t1_wr_rdata", rsp_data_a[ri(base)], 32'd0);
        chk("t1_wr_lat", 32'(rsp_cyc_a[ri(base)] - a0), 32'd2);
        chk("t1_rd_data", rsp_data_a[ri(base + 1)], 32'hDEAD_BEEF);
        chk("t1_rd_err", 32'(rsp_err_a[ri(base + 1)]), 32'd0);
        chk("t1_rd_lat", 32'(rsp_cyc_a[ri(base + 1)] - a1), 32'd2);

        // 8 writes + 8 reads back-to-back.
        base = rsp_n;
        for (int i = 0; i < 8; i++) send(32'h8000_0000 + 32'(4 * i), 1'b1, 2'd2, wdat(i), acc_a[i]);
        for (int i = 0; i < 8; i++) begin
            send(32'h8000_0000 + 32'(4 * i), 1'b0, 2'd2, 32'h0, acc_a[8 + i]);
            exp_q.push_back(wdat(i));
        end
        wait_rsp(base, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_nonseq", 32'(htr_log[li(acc_a[0] + i)]), 32'(T_NONSEQ));
            chk("t2_haddr", adr_log[li(acc_a[0] + i)], 32'h8000_0000 + 32'(4 * (i % 8)));
            chk("t2_rsp_cycle", 32'(rsp_cyc_a[ri(base + i)] - rsp_cyc_a[ri(base)]), 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            chk("t2_rd_data", rsp_data_a[ri(base + 8 + i)], e);
        end

        // Two wait states on the data phase of the middle read.
        wait_addr = 32'h8000_0004; wait_n = 2;
        base = rsp_n;
        send(32'h8000_0000, 1'b0, 2'd2, 32'h0, a0);
        send(32'h8000_0004, 1'b0, 2'd2, 32'h0, a1);
        send(32'h8000_0008, 1'b0, 2'd2, 32'h0, b0);
        @(negedge clk); #1;
        chk("t3_ready_w1", 32'(req_ready), 32'd0);
        chk("t3_haddr_w1", haddr, 32'h8000_0008);
        @(negedge clk); #1;
        chk("t3_ready_w2", 32'(req_ready), 32'd0);
        chk("t3_haddr_w2", haddr, 32'h8000_0008);
        @(negedge clk); #1;
        chk("t3_ready_end", 32'(req_ready), 32'd1);
        chk("t3_haddr_end", haddr, 32'h8000_0008);
        wait_rsp(base, 3);
        chk("t3_lat0", 32'(rsp_cyc_a[ri(base)] - a0), 32'd2);
        chk("t3_lat1", 32'(rsp_cyc_a[ri(base + 1)] - a0), 32'd5);
        chk("t3_lat2", 32'(rsp_cyc_a[ri(base + 2)] - a0), 32'd6);
        for (int i = 0; i < 3; i++) chk("t3_data", rsp_data_a[ri(base + i)], wdat(i));
        wait_addr = 32'hFFFF_FFFC; wait_n = 0;

        // ERROR on 0x100 with a read of 0x8000_0004 pipelined behind it.
        err_addr = 32'h0000_0100;
        base = rsp_n;
        send(32'h0000_0100, 1'b0, 2'd2, 32'h0, x);
        send(32'h8000_0004, 1'b0, 2'd2, 32'h0, y);
        wait_rsp(base, 2);
        repeat (2) @(negedge clk);
        chk("t4_first_nonseq", 32'(htr_log[li(x + 1)]), 32'(T_NONSEQ));
        chk("t4_idle_slot", 32'(htr_log[li(x + 2)]), 32'(T_IDLE));
        chk("t4_reissue", 32'(htr_log[li(x + 3)]), 32'(T_NONSEQ));
        chk("t4_reissue_addr", adr_log[li(x + 3)], 32'h8000_0004);
        cnt = 0;
        for (int c = x; c <= x + 6; c++)
            if (htr_log[li(c)] == T_NONSEQ && adr_log[li(c)] == 32'h8000_0004) cnt++;
        chk("t4_issue_count", 32'(cnt), 32'd2);
        chk("t4_err0", 32'(rsp_err_a[ri(base)]), 32'd1);
        chk("t4_rdata0", rsp_data_a[ri(base)], 32'd0);
        chk("t4_lat0", 32'(rsp_cyc_a[ri(base)] - x), 32'd3);
        chk("t4_err1", 32'(rsp_err_a[ri(base + 1)]), 32'd0);
        chk("t4_rdata1", rsp_data_a[ri(base + 1)], wdat(1));
        chk("t4_lat1", 32'(rsp_cyc_a[ri(base + 1)] - x), 32'd5);
        err_addr = 32'hFFFF_FFF0;

`ifdef AHB_LITE_MASTER_SUBWORD_EN
        // Byte write replicated across lanes, word readback, misaligned half read.
        base = rsp_n;
        send(32'h8000_0003, 1'b1, 2'd0, 32'h0000_00A5, a0);
        send(32'h8000_0000, 1'b0, 2'd2, 32'h0, a1);
        wait_rsp(base, 2);
        chk("t5_hsize", 32'(hsz_log[li(a0)]), 32'd0);
        chk("t5_haddr", adr_log[li(a0)], 32'h8000_0003);
        chk("t5_hwdata", hwd_log[li(a0 + 1)], 32'hA5A5_A5A5);
        e = wdat(0);
        e[31:24] = 8'hA5;
        chk("t5_readback", rsp_data_a[ri(base + 1)], e);
        base = rsp_n;
        send(32'h8000_0001, 1'b0, 2'd1, 32'h0, b0);
        wait_rsp(base, 1);
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int c = b0; c <= b0 + 3; c++) if (htr_log[li(c)] == T_NONSEQ) cnt++;
        chk("t5_mis_no_nonseq", 32'(cnt), 32'd0);
        chk("t5_mis_err", 32'(rsp_err_a[ri(base)]), 32'd1);
        chk("t5_mis_rdata", rsp_data_a[ri(base)], 32'd0);
`else
        // Without sub-word support the size is ignored and the address is word-aligned.
        base = rsp_n;
        send(32'h8000_0013, 1'b1, 2'd0, 32'h1234_5678, a0);
        send(32'h8000_0012, 1'b0, 2'd1, 32'h0, a1);
        wait_rsp(base, 2);
        chk("t5_wr_haddr", adr_log[li(a0)], 32'h8000_0010);
        chk("t5_wr_hsize", 32'(hsz_log[li(a0)]), 32'd2);
        chk("t5_rd_haddr", adr_log[li(a1)], 32'h8000_0010);
        chk("t5_rd_data", rsp_data_a[ri(base + 1)], 32'h1234_5678);
        chk("t5_rd_err", 32'(rsp_err_a[ri(base + 1)]), 32'd0);
`endif

        // Asynchronous reset in the middle of a wait-stated data phase.
        wait_addr = 32'h8000_0008; wait_n = 6;
        base = rsp_n;
        send(32'h8000_0008, 1'b0, 2'd2, 32'h0, a0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_addr = 32'hFFFF_FFFC; wait_n = 0;
        repeat (10) @(negedge clk);
        #2 chk("t6_no_rsp_after_reset", 32'(rsp_n - base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
